// File: rtl/bp_fpga_host_uart_rx_if.sv
// Output handshake between the UART receiver and the NBF packet assembler.
// The receiver drives data_o/v_o; the consumer pulses yumi_i to take a byte.
interface bp_fpga_host_uart_rx_if #(
    parameter int data_bits_p = 8
);
    logic [data_bits_p-1:0] data_o;
    logic                   v_o;
    logic                   yumi_i;

    modport master (output data_o, output v_o, input yumi_i);
    modport slave  (input data_o, input v_o, output yumi_i);
endinterface

// File: rtl/bp_fpga_host_uart_rx.sv
// UART receive front end for the FPGA host.
// Deserializes rx_i (idle high, LSB first) into bytes on a one-entry valid/yumi
// output register. Filters start-bit glitches, checks optional parity and the
// stop bit(s), and reports framing, parity and overrun errors on a sticky flag.
// Optional build macro: BP_FPGA_HOST_UART_RX_SYNC_EN adds a 2-flop synchronizer
// on rx_i (reset to 1), delaying all rx timing by two cycles.
module bp_fpga_host_uart_rx #(
    parameter int uart_clk_per_bit_p = 10416,
    parameter int uart_data_bits_p   = 8,
    parameter int uart_parity_bit_p  = 0,
    parameter int uart_parity_odd_p  = 0,
    parameter int uart_stop_bits_p   = 1
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        rx_i,
    bp_fpga_host_uart_rx_if.master      out_if,
    output logic                        error_o,
    output logic                        frame_err_o,
    output logic                        parity_err_o
);

    localparam int              CW        = $clog2(uart_clk_per_bit_p);
    localparam logic [CW-1:0]   HALF_LAST = CW'(uart_clk_per_bit_p / 2 - 1);
    localparam logic [CW-1:0]   BIT_LAST  = CW'(uart_clk_per_bit_p - 1);
    localparam logic [3:0]      DATA_LAST = 4'(uart_data_bits_p - 1);
    localparam logic            STOP_LAST = 1'(uart_stop_bits_p - 1);
    localparam logic            PAR_ODD   = 1'(uart_parity_odd_p);
    localparam logic            PAR_EN    = (uart_parity_bit_p != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_e;

    // Expected parity bit for a received data word.
    function automatic logic calc_parity(input logic [uart_data_bits_p-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    state_e                       state_q;
    logic [CW-1:0]                cnt_q;
    logic [3:0]                   bit_cnt_q;
    logic                         stop_cnt_q;
    logic [uart_data_bits_p-1:0]  shift_q;
    logic [uart_data_bits_p-1:0]  shift_d;
    logic                         par_bad_q;
    logic [uart_data_bits_p-1:0]  data_q;
    logic                         v_q;
    logic                         error_q;
    logic                         frame_err_q;
    logic                         parity_err_q;
    logic                         rx_s;
    logic                         bit_tick_s;
    logic                         par_exp_s;

`ifdef BP_FPGA_HOST_UART_RX_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer for a raw pin; resets to the idle (high) level.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_i};
        end
    end

    assign rx_s = sync_q[1];
`else
    assign rx_s = rx_i;
`endif

    // Bit-centre strobe, next shift value and expected parity for the FSM.
    always_comb begin
        bit_tick_s = (cnt_q == BIT_LAST);
        shift_d    = {rx_s, shift_q[uart_data_bits_p-1:1]};
        par_exp_s  = calc_parity(shift_q, PAR_ODD);
    end

    // Receive FSM with bit timer, output register and error flags.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= 4'd0;
            stop_cnt_q   <= 1'b0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            data_q       <= '0;
            v_q          <= 1'b0;
            error_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            if (v_q && out_if.yumi_i) begin
                v_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                    end
                end
                S_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            // Line went back high before mid-bit: a glitch, not a start.
                            state_q <= S_IDLE;
                        end else begin
                            state_q   <= S_DATA;
                            bit_cnt_q <= 4'd0;
                            par_bad_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (bit_tick_s) begin
                        cnt_q   <= '0;
                        shift_q <= shift_d;
                        if (bit_cnt_q == DATA_LAST) begin
                            state_q    <= PAR_EN ? S_PARITY : S_STOP;
                            stop_cnt_q <= 1'b0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_PARITY: begin
                    if (bit_tick_s) begin
                        cnt_q      <= '0;
                        state_q    <= S_STOP;
                        stop_cnt_q <= 1'b0;
                        if (rx_s != par_exp_s) begin
                            // Still walk through the stop bit so it is not taken as a start.
                            parity_err_q <= 1'b1;
                            error_q      <= 1'b1;
                            par_bad_q    <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_STOP: begin
                    if (bit_tick_s) begin
                        cnt_q <= '0;
                        if (!rx_s) begin
                            frame_err_q <= 1'b1;
                            error_q     <= 1'b1;
                            state_q     <= S_BREAK;
                        end else if (stop_cnt_q == STOP_LAST) begin
                            // Return to idle half a bit early to absorb baud skew.
                            state_q <= S_IDLE;
                            if (!par_bad_q) begin
                                if (!v_q || out_if.yumi_i) begin
                                    data_q <= shift_q;
                                    v_q    <= 1'b1;
                                end else begin
                                    error_q <= 1'b1;
                                end
                            end
                        end else begin
                            stop_cnt_q <= stop_cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign out_if.data_o = data_q;
    assign out_if.v_o    = v_q;
    assign error_o       = error_q;
    assign frame_err_o   = frame_err_q;
    assign parity_err_o  = parity_err_q;

endmodule

// File: tb/tb_bp_fpga_host_uart_rx.sv
// Self-checking bench: an 8N1 receiver at 16 clk/bit and an 8E1 receiver at
// 17 clk/bit, driven by a frame generator and compared against byte queues
// built from the serial framing rules.
module tb_bp_fpga_host_uart_rx;

    localparam int PN = 16;
    localparam int PE = 17;
    localparam int W  = 8;
`ifdef BP_FPGA_HOST_UART_RX_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic clk     = 1'b0;
    logic reset_i = 1'b1;
    logic rx_n    = 1'b1;
    logic rx_e    = 1'b1;
    logic err_n, ferr_n, perr_n;
    logic err_e, ferr_e, perr_e;

    bp_fpga_host_uart_rx_if #(.data_bits_p(W)) if_n ();
    bp_fpga_host_uart_rx_if #(.data_bits_p(W)) if_e ();

    bp_fpga_host_uart_rx #(
        .uart_clk_per_bit_p(PN), .uart_data_bits_p(W), .uart_parity_bit_p(0),
        .uart_parity_odd_p(0), .uart_stop_bits_p(1)
    ) u_n (
        .clk_i(clk), .reset_i(reset_i), .rx_i(rx_n), .out_if(if_n),
        .error_o(err_n), .frame_err_o(ferr_n), .parity_err_o(perr_n)
    );

    bp_fpga_host_uart_rx #(
        .uart_clk_per_bit_p(PE), .uart_data_bits_p(W), .uart_parity_bit_p(1),
        .uart_parity_odd_p(0), .uart_stop_bits_p(1)
    ) u_e (
        .clk_i(clk), .reset_i(reset_i), .rx_i(rx_e), .out_if(if_e),
        .error_o(err_e), .frame_err_o(ferr_e), .parity_err_o(perr_e)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    logic [7:0] got_n[$], got_e[$], exp_n[$], exp_e[$];
    int  fcnt_n = 0, pcnt_n = 0, fcnt_e = 0, pcnt_e = 0;
    int  vcyc_n = 0, rise_n = 0, start_n = 0;
    bit  vprev_n = 1'b0;
    bit  auto_n = 1'b1, auto_e = 1'b1;
    bit  man_n = 1'b0;

    // Cycle stamp for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    // Consumer and pulse monitor for the 8N1 receiver.
    always @(negedge clk) begin
        if (if_n.v_o) vcyc_n <= vcyc_n + 1;
        if (if_n.v_o && !vprev_n) rise_n <= cyc;
        vprev_n <= if_n.v_o;
        if (ferr_n) fcnt_n <= fcnt_n + 1;
        if (perr_n) pcnt_n <= pcnt_n + 1;
        if (auto_n && if_n.v_o) got_n.push_back(if_n.data_o);
        if_n.yumi_i <= auto_n ? if_n.v_o : man_n;
    end

    // Consumer and pulse monitor for the 8E1 receiver.
    always @(negedge clk) begin
        if (ferr_e) fcnt_e <= fcnt_e + 1;
        if (perr_e) pcnt_e <= pcnt_e + 1;
        if (auto_e && if_e.v_o) got_e.push_back(if_e.data_o);
        if_e.yumi_i <= auto_e ? if_e.v_o : 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int which, input logic val, input int n);
        if (which == 0) rx_n = val; else rx_e = val;
        repeat (n) @(negedge clk);
    endtask

    // Serial frame: start, data LSB first, even parity on the E line, one stop.
    task automatic send(input int which, input logic [7:0] b, input bit bad_par, input bit bad_stop);
        int   p   = (which == 0) ? PN : PE;
        logic par = (^b) ^ bad_par;
        if (which == 0) start_n = cyc;
        drive(which, 1'b0, p);
        for (int i = 0; i < W; i++) drive(which, b[i], p);
        if (which == 1) drive(which, par, p);
        drive(which, !bad_stop, p);
    endtask

    task automatic cmp_queue(input string tag, input int which);
        logic [7:0] g[$];
        logic [7:0] e[$];
        if (which == 0) begin g = got_n; e = exp_n; got_n.delete(); exp_n.delete(); end
        else            begin g = got_e; e = exp_e; got_e.delete(); exp_e.delete(); end
        check({tag, "_cnt"}, 32'(g.size()), 32'(e.size()));
        for (int i = 0; i < e.size(); i++) begin
            if (i < g.size()) check(tag, 32'(g[i]), 32'(e[i]));
        end
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        got_n.delete(); got_e.delete(); exp_n.delete(); exp_e.delete();
        fcnt_n = 0; pcnt_n = 0; fcnt_e = 0; pcnt_e = 0; vcyc_n = 0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Reset state
        check("rst_v_n",   32'(if_n.v_o),    32'd0);
        check("rst_d_n",   32'(if_n.data_o), 32'd0);
        check("rst_err_n", 32'(err_n),       32'd0);
        check("rst_v_e",   32'(if_e.v_o),    32'd0);
        check("rst_err_e", 32'(err_e),       32'd0);

        // 8N1 0xA5 with immediate yumi: value, one-cycle valid, latency
        send(0, 8'hA5, 1'b0, 1'b0); exp_n.push_back(8'hA5);
        drive(0, 1'b1, 8);
        cmp_queue("a5", 0);
        check("a5_vcyc", 32'(vcyc_n), 32'd1);
        check("a5_lat",  32'(rise_n), 32'(start_n + 1 + PN / 2 + PN * 9 + SYNC));
        check("a5_err",  32'(err_n),  32'd0);

        // 8E1: good parity, bad parity, then good byte
        send(1, 8'h03, 1'b0, 1'b0); exp_e.push_back(8'h03);
        send(1, 8'h03, 1'b1, 1'b0);
        send(1, 8'h7E, 1'b0, 1'b0); exp_e.push_back(8'h7E);
        drive(1, 1'b1, 8);
        cmp_queue("par", 1);
        check("par_pulses", 32'(pcnt_e), 32'd1);
        check("par_ferr",   32'(fcnt_e), 32'd0);
        check("par_err",    32'(err_e),  32'd1);

        // Start glitch of 5 cycles is filtered
        drive(0, 1'b0, 5);
        drive(0, 1'b1, 30);
        send(0, 8'h11, 1'b0, 1'b0); exp_n.push_back(8'h11);
        drive(0, 1'b1, 8);
        cmp_queue("glitch", 0);
        check("glitch_err", 32'(err_n), 32'd0);

        // Framing error with line held low, then recovery
        send(0, 8'h55, 1'b0, 1'b1);
        drive(0, 1'b0, 40);
        drive(0, 1'b1, 20);
        check("brk_ferr", 32'(fcnt_n), 32'd1);
        check("brk_err",  32'(err_n),  32'd1);
        send(0, 8'h22, 1'b0, 1'b0); exp_n.push_back(8'h22);
        drive(0, 1'b1, 8);
        cmp_queue("brk", 0);
        check("brk_ferr2", 32'(fcnt_n), 32'd1);

        // Overrun: two frames with no consumer
        do_reset();
        auto_n = 1'b0;
        send(0, 8'h01, 1'b0, 1'b0);
        send(0, 8'h02, 1'b0, 1'b0);
        drive(0, 1'b1, 8);
        check("ovr_v",   32'(if_n.v_o),    32'd1);
        check("ovr_d",   32'(if_n.data_o), 32'h01);
        check("ovr_err", 32'(err_n),       32'd1);
        man_n = 1'b1;
        @(negedge clk);
        man_n = 1'b0;
        @(negedge clk);
        check("ovr_vdrop", 32'(if_n.v_o), 32'd0);
        drive(0, 1'b1, 3 * PN);
        check("ovr_vstay", 32'(if_n.v_o), 32'd0);
        auto_n = 1'b1;

        // Reset in the middle of a 0xFF frame
        do_reset();
        fork
            send(0, 8'hFF, 1'b0, 1'b0);
            begin
                repeat (40) @(negedge clk);
                reset_i = 1'b1;
                repeat (2) @(negedge clk);
                reset_i = 1'b0;
            end
        join
        send(0, 8'h10, 1'b0, 1'b0); exp_n.push_back(8'h10);
        drive(0, 1'b1, 8);
        cmp_queue("midrst", 0);
        check("midrst_err", 32'(err_n), 32'd0);

        // Randomized traffic on both lines
        do_reset();
        begin
            int exp_perr = 0;
            for (int k = 0; k < 16; k++) begin
                logic [7:0] b = 8'($urandom_range(0, 255));
                send(0, b, 1'b0, 1'b0); exp_n.push_back(b);
                drive(0, 1'b1, $urandom_range(0, 5));
            end
            for (int k = 0; k < 16; k++) begin
                logic [7:0] b   = 8'($urandom_range(0, 255));
                bit         bad = ($urandom_range(0, 3) == 0);
                send(1, b, bad, 1'b0);
                if (bad) exp_perr++; else exp_e.push_back(b);
                drive(1, 1'b1, $urandom_range(0, 5));
            end
            drive(1, 1'b1, 8);
            cmp_queue("rnd_n", 0);
            cmp_queue("rnd_e", 1);
            check("rnd_perr", 32'(pcnt_e), 32'(exp_perr));
            check("rnd_ferr", 32'(fcnt_n + fcnt_e), 32'd0);
            check("rnd_err_n", 32'(err_n), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
